// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter that multiplexes NUM_PORTS cache-line requesters onto one memory port.
// The winner's command is captured at grant and held stable until mem_resp completes it.
module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    localparam int IDW       = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    output logic [NUM_PORTS*LINE_WIDTH-1:0] req_rdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [LINE_WIDTH-1:0]           mem_wdata,
    output logic                            mem_read,
    output logic                            mem_write,
    input  logic [LINE_WIDTH-1:0]           mem_rdata,
    input  logic                            mem_resp,
    output logic                            busy,
    output logic [IDW-1:0]                  grant_id
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    logic                 state;
    logic [IDW-1:0]       ptr;
    logic [NUM_PORTS-1:0] requesting;
    logic [IDW-1:0]       winner;
    logic                 any_req;

    assign requesting = req_read | req_write;
    assign busy       = (state == ST_BUSY);

    // First requesting port at or after ptr, searching circularly upward.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(ptr) + k) % NUM_PORTS;
            if (!any_req && requesting[idx]) begin
                any_req = 1'b1;
                winner  = IDW'(idx);
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state     <= ST_BUSY;
                        grant_id  <= winner;
                        ptr       <= (winner == IDW'(NUM_PORTS - 1)) ? '0 : winner + IDW'(1);
                        mem_addr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata <= req_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
                        // A port raising both read and write is served as a write.
                        mem_write <= req_write[winner];
                        mem_read  <= ~req_write[winner];
                    end
                end
                default: begin
                    if (mem_resp) begin
                        state     <= ST_IDLE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Completion is routed straight through so the requester sees it with no added latency.
    always_comb begin
        req_resp  = '0;
        req_rdata = '0;
        if (state == ST_BUSY && mem_resp) begin
            req_resp[grant_id] = 1'b1;
            req_rdata[int'(grant_id)*LINE_WIDTH +: LINE_WIDTH] = mem_rdata;
        end
    end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-port round-robin arbiter between cache-line requesters (I-cache, D-cache, prefetcher, and so on) and the single physical-memory port. It grants one requester at a time. At grant it latches that requester's address, write data and command, so the memory side sees a stable request for the whole transaction. A rotating priority pointer guarantees no requester waits more than NUM_PORTS−1 transactions.

## Interface
Parameters:
- NUM_PORTS, 2: number of requesters; legal range 2..8.
- ADDR_WIDTH, 32: address width in bits.
- LINE_WIDTH, 256: cache-line width in bits.

Ports (port i occupies bit slice [i*W +: W] of each flattened bus):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port line address.
- req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line.
- req_read  in  NUM_PORTS  per-port read request.
- req_write  in  NUM_PORTS  per-port write request.
- req_rdata  out  NUM_PORTS*LINE_WIDTH  per-port read line.
- req_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write line.
- mem_read  out  1  memory read command.
- mem_write  out  1  memory write command.
- mem_rdata  in  LINE_WIDTH  memory read line.
- mem_resp  in  1  memory completion.
- busy  out  1  transaction outstanding.
- grant_id  out  $clog2(NUM_PORTS)  index of the granted port; valid while busy.

## Operation
- States: IDLE and BUSY.
- IDLE:
  - Port i is requesting when req_read[i] | req_write[i].
  - If any port requests, the winner is the first requesting port at or after ptr, searching circularly upward.
  - On the winner, the block latches grant_id, address, wdata and cmd. cmd = write if req_write is set, else read; write wins if both are set.
  - Next state is BUSY. ptr is set to (winner+1) mod NUM_PORTS.
- BUSY:
  - mem_addr, mem_wdata, mem_read and mem_write are driven from the latched registers only.
  - Requester inputs are ignored. A requester that drops or changes its request mid-transaction does not affect the memory command.
  - On mem_resp:
    - req_resp[grant_id] = 1 combinationally.
    - req_rdata slice grant_id = mem_rdata combinationally. This is valid for both read and write; for writes the requester ignores it.
    - Next state is IDLE.
- Non-granted req_resp bits are always 0. Non-granted req_rdata slices are 0.
- Reset values:
  - state IDLE, ptr 0.
  - mem_read, mem_write and busy 0.
  - mem_addr and mem_wdata 0.
  - req_resp all 0, grant_id 0.
- Reset asserted mid-transaction: the block returns to IDLE the next edge, drops mem_read/mem_write and issues no req_resp. The memory model is reset by the same rst.
- mem_resp in IDLE is ignored. It produces no req_resp and no state change.

## Timing
- Cycle 0: request visible in IDLE.
- Cycle 1: mem_read or mem_write is high from a register, and busy = 1.
- Response: req_resp rises in the same cycle as mem_resp (zero added latency).
- Minimum transaction length is 2 cycles: grant edge, then resp cycle.
- After a resp cycle the block spends at least 1 cycle in IDLE. This turnaround lets the finished requester deassert, so it is not re-granted on a stale request.
- Back-to-back: port A resp at cycle n, port B (pending) grant registered at edge n+2, mem command at cycle n+2.
- Single requester held continuously is re-granted every turnaround, because ptr skips only non-requesting ports.
- Fairness bound: with all ports requesting continuously, grants follow the order ptr, ptr+1, ... wrapping mod NUM_PORTS.
- Outputs mem_* and busy are glitch-free registered values. req_resp and req_rdata are combinational from mem_resp/mem_rdata.

## Test plan
- Reset, then idle 5 cycles:
  - mem_read = mem_write = busy = 0 and req_resp = 0 every cycle.
  - mem_resp pulsed in IDLE yields no req_resp.
- Single read, NUM_PORTS=2:
  - Stimulus: port 1 reads addr 0x0000_1040; memory responds after 4 cycles with 0xA5…A5.
  - Required: mem_addr = 0x0000_1040 from cycle 1; req_resp[1] pulses in the mem_resp cycle; req_rdata slice 1 = 0xA5…A5; busy falls the next cycle.
- Simultaneous requests, NUM_PORTS=4:
  - Stimulus: all ports assert at once after reset; each port drops its request on its resp.
  - Required: grant order 0,1,2,3; no port is granted twice before all are served.
- Wrap-around with a held request:
  - Stimulus: after a port 3 grant, ports 0 and 3 keep requesting.
  - Required: port 0 is granted next, then 3, alternating.
- Mid-transaction request change:
  - Stimulus: port 0 write to 0x200 with data D is granted; port 0 then changes addr to 0x300 and drops req_write before mem_resp.
  - Required: mem_addr stays 0x200, mem_wdata stays D, mem_write stays 1; req_resp[0] still pulses.
- Reset mid-transaction and read+write conflict:
  - Stimulus: rst asserted while BUSY.
  - Required: mem_read falls the next cycle and no req_resp is issued.
  - Stimulus: a later request with read and write both set.
  - Required: issued as mem_write.
